// File: rtl/fetch_pkg.sv
// Shared types and helpers for the queued fetch stage: opcodes, queue entry
// layout, FSM state encoding and immediate decoders for early target calculation.
package fetch_pkg;

    localparam logic [6:0]  OP_JAL    = 7'b1101111;
    localparam logic [6:0]  OP_BRANCH = 7'b1100011;
    localparam logic [31:0] NOP_INSTR = 32'h00000033;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        DRAIN
    } fetch_state_e;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
        logic [31:0] pc_p4;
        logic [31:0] target;
        logic        pred_taken;
    } fq_entry_t;

    // Sign-extended J-type immediate (JAL offset)
    function automatic logic [31:0] imm_j(input logic [31:0] instr);
        return {{12{instr[31]}}, instr[19:12], instr[20], instr[30:21], 1'b0};
    endfunction

    // Sign-extended B-type immediate (conditional branch offset)
    function automatic logic [31:0] imm_b(input logic [31:0] instr);
        return {{20{instr[31]}}, instr[7], instr[30:25], instr[11:8], 1'b0};
    endfunction

endpackage

// File: rtl/fetch_queue.sv
// Instruction queue: DEPTH-entry FIFO of fq_entry_t with synchronous flush.
// Push and pop may happen in the same cycle, including when full.
module fetch_queue
    import fetch_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       i_flush,
    input  logic                       i_push,
    input  fq_entry_t                  i_push_data,
    input  logic                       i_pop,
    output fq_entry_t                  o_head,
    output logic                       o_head_valid,
    output logic [$clog2(DEPTH):0]     o_count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W:0] FULL_CNT = (PTR_W + 1)'(DEPTH);

    fq_entry_t        r_mem [DEPTH];
    logic [PTR_W-1:0] r_rd_ptr;
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W:0]   r_count;

    logic w_do_pop;
    logic w_do_push;

    assign w_do_pop  = i_pop && (r_count != '0);
    assign w_do_push = i_push && ((r_count != FULL_CNT) || w_do_pop);

    // Pointer and occupancy bookkeeping; flush wins over push/pop
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else if (i_flush) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            r_count <= r_count + {{PTR_W{1'b0}}, w_do_push} - {{PTR_W{1'b0}}, w_do_pop};
        end
    end

    // Entry storage write
    // NOTE: storage has no reset; r_count gates every read, so stale contents are never observed.
    always_ff @(posedge clk) begin
        if (w_do_push && !i_flush) r_mem[r_wr_ptr] <= i_push_data;
    end

    assign o_head       = r_mem[r_rd_ptr];
    assign o_head_valid = (r_count != '0);
    assign o_count      = r_count;

endmodule

// File: rtl/fetch_queued.sv
// Queued fetch stage: PC generation, single-outstanding L1I requests, early
// JAL/branch prediction with an inline 2-bit BHT, and an instruction queue to decode.
// Optional FETCH_PERF_EN adds perf_fetched / perf_redirects / perf_full_cycles counters.
module fetch_queued
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0,
    parameter int          FQ_DEPTH = 4,
    parameter int          BP_IDX_W = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                mispredict,
    input  logic [31:0]         override_addr,
    input  logic                mstall,
    input  logic                bp_we,
    input  logic [BP_IDX_W-1:0] bp_w_addr,
    input  logic                bp_did_branch,
    output logic                ic_req,
    output logic [31:0]         ic_addr,
    input  logic                ic_gnt,
    input  logic                ic_valid,
    input  logic [31:0]         ic_data,
    output logic                f_valid,
    input  logic                dec_ready,
    output logic [31:0]         f_instr,
    output logic [31:0]         f_pc,
    output logic [31:0]         f_pc_p4,
    output logic [31:0]         f_target,
    output logic                f_pred_taken
`ifdef FETCH_PERF_EN
    ,
    output logic [31:0]         perf_fetched,
    output logic [31:0]         perf_redirects,
    output logic [31:0]         perf_full_cycles
`endif
);

    localparam int               CNT_W    = $clog2(FQ_DEPTH) + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(FQ_DEPTH);
    localparam int               BHT_SIZE = 2 ** BP_IDX_W;

    fetch_state_e r_state;
    fetch_state_e w_state_next;
    logic [31:0]  r_pc;
    logic [1:0]   r_bht [BHT_SIZE];

    logic [BP_IDX_W-1:0] w_bht_idx;
    logic [1:0]          w_bht_ctr;
    logic [6:0]          w_opcode;
    logic                w_is_jal;
    logic                w_is_branch;
    logic                w_pred;
    logic [31:0]         w_imm;
    logic [31:0]         w_target;
    logic [31:0]         w_pc_p4;
    logic                w_resp_accept;
    logic                w_enq;
    logic                w_deq;
    logic                w_grant;
    logic                w_full;
    logic [CNT_W-1:0]    w_count;
    logic                w_head_valid;
    fq_entry_t           w_head;
    fq_entry_t           w_enq_entry;

    // Early decode of the returning word for prediction and target
    assign w_bht_idx   = r_pc[BP_IDX_W+1:2];
    assign w_bht_ctr   = r_bht[w_bht_idx];
    assign w_opcode    = ic_data[6:0];
    assign w_is_jal    = (w_opcode == OP_JAL);
    assign w_is_branch = (w_opcode == OP_BRANCH);
    assign w_pred      = w_is_jal || (w_is_branch && w_bht_ctr[1]);
    assign w_imm       = w_is_jal ? imm_j(ic_data) : imm_b(ic_data);
    assign w_target    = r_pc + w_imm;
    assign w_pc_p4     = r_pc + 32'd4;

    // A response is only consumed in WAIT; a redirect in that cycle throws it away
    assign w_resp_accept = (r_state == WAIT) && ic_valid;
    assign w_enq         = w_resp_accept && !mispredict;
    assign w_deq         = w_head_valid && dec_ready && !mstall;
    assign w_full        = (w_count == FULL_CNT);
    assign w_grant       = ic_req && ic_gnt;

    assign w_enq_entry = '{instr:      ic_data,
                           pc:         r_pc,
                           pc_p4:      w_pc_p4,
                           target:     w_target,
                           pred_taken: w_pred};

    fetch_queue #(
        .DEPTH(FQ_DEPTH)
    ) u_queue (
        .clk          (clk),
        .rst_n        (rst_n),
        .i_flush      (mispredict),
        .i_push       (w_enq),
        .i_push_data  (w_enq_entry),
        .i_pop        (w_deq),
        .o_head       (w_head),
        .o_head_valid (w_head_valid),
        .o_count      (w_count)
    );

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_state_next;
    end

    // FSM next state: a redirect while a request is in flight forces DRAIN
    // NOTE: every always_comb output gets a default first so no path infers a latch.
    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            IDLE:    if (w_grant) w_state_next = mispredict ? DRAIN : WAIT;
            WAIT: begin
                if (ic_valid)        w_state_next = IDLE;
                else if (mispredict) w_state_next = DRAIN;
            end
            DRAIN:   if (ic_valid) w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    // FSM outputs: request only from IDLE while the queue has a free slot
    always_comb begin
        ic_req = 1'b0;
        if (rst_n && (r_state == IDLE) && !w_full) ic_req = 1'b1;
    end

    assign ic_addr = {r_pc[31:2], 2'b00};

    // PC update: redirect first, otherwise advance on each consumed response
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)             r_pc <= RESET_PC;
        else if (mispredict)    r_pc <= override_addr;
        else if (w_resp_accept) r_pc <= w_pred ? w_target : w_pc_p4;
    end

    // BHT training: saturating 2-bit counters, weakly not-taken after reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < BHT_SIZE; i++) r_bht[i] <= 2'b01;
        end else if (bp_we) begin
            if (bp_did_branch) begin
                if (r_bht[bp_w_addr] != 2'b11) r_bht[bp_w_addr] <= r_bht[bp_w_addr] + 2'd1;
            end else begin
                if (r_bht[bp_w_addr] != 2'b00) r_bht[bp_w_addr] <= r_bht[bp_w_addr] - 2'd1;
            end
        end
    end

    // Decode-facing head fields; a bubble presents as NOP, not taken
    assign f_valid      = w_head_valid;
    assign f_instr      = w_head_valid ? w_head.instr : NOP_INSTR;
    assign f_pc         = w_head.pc;
    assign f_pc_p4      = w_head.pc_p4;
    assign f_target     = w_head.target;
    assign f_pred_taken = w_head_valid && w_head.pred_taken;

`ifdef FETCH_PERF_EN
    // Wrapping event counters
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_fetched     <= '0;
            perf_redirects   <= '0;
            perf_full_cycles <= '0;
        end else begin
            if (w_enq)      perf_fetched     <= perf_fetched + 32'd1;
            if (mispredict) perf_redirects   <= perf_redirects + 32'd1;
            if (w_full)     perf_full_cycles <= perf_full_cycles + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_fetch_queued.sv
// Self-checking bench for fetch_queued: L1I responder model, scoreboard of
// expected queue entries pushed on each response and popped on each dequeue.
module tb_fetch_queued;

    localparam int          FQ_DEPTH = 4;
    localparam int          BP_IDX_W = 8;
    localparam logic [31:0] JAL16    = 32'h0100006F;
    localparam logic [31:0] BEQ_M8   = 32'hFE000CE3;
    localparam logic [31:0] ADDI     = 32'h00100093;

    logic                clk;
    logic                rst_n;
    logic                mispredict;
    logic [31:0]         override_addr;
    logic                mstall;
    logic                bp_we;
    logic [BP_IDX_W-1:0] bp_w_addr;
    logic                bp_did_branch;
    logic                ic_req;
    logic [31:0]         ic_addr;
    logic                ic_gnt;
    logic                ic_valid;
    logic [31:0]         ic_data;
    logic                f_valid;
    logic                dec_ready;
    logic [31:0]         f_instr;
    logic [31:0]         f_pc;
    logic [31:0]         f_pc_p4;
    logic [31:0]         f_target;
    logic                f_pred_taken;
`ifdef FETCH_PERF_EN
    logic [31:0]         perf_fetched;
    logic [31:0]         perf_redirects;
    logic [31:0]         perf_full_cycles;
`endif

    logic gnt_en;
    assign ic_gnt = ic_req & gnt_en;

    fetch_queued #(
        .RESET_PC (32'h0),
        .FQ_DEPTH (FQ_DEPTH),
        .BP_IDX_W (BP_IDX_W)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .mispredict    (mispredict),
        .override_addr (override_addr),
        .mstall        (mstall),
        .bp_we         (bp_we),
        .bp_w_addr     (bp_w_addr),
        .bp_did_branch (bp_did_branch),
        .ic_req        (ic_req),
        .ic_addr       (ic_addr),
        .ic_gnt        (ic_gnt),
        .ic_valid      (ic_valid),
        .ic_data       (ic_data),
        .f_valid       (f_valid),
        .dec_ready     (dec_ready),
        .f_instr       (f_instr),
        .f_pc          (f_pc),
        .f_pc_p4       (f_pc_p4),
        .f_target      (f_target),
        .f_pred_taken  (f_pred_taken)
`ifdef FETCH_PERF_EN
        ,
        .perf_fetched     (perf_fetched),
        .perf_redirects   (perf_redirects),
        .perf_full_cycles (perf_full_cycles)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int total = 0;
    int bad   = 0;
    int n_enq   = 0;
    int n_grant = 0;
    int resp_delay = 0;

    typedef struct {
        logic [31:0] instr;
        logic [31:0] pc;
        logic [31:0] target;
        logic        pred;
        logic        chk_tgt;
    } exp_t;

    exp_t        exp_q [$];
    exp_t        mon_e;
    logic [1:0]  bht_m [2**BP_IDX_W];
    logic [31:0] resp_addr;
    logic        resp_stale;
    logic [31:0] rs_addr;
    logic        rs_stale;

    // Program image seen by the fetch stage
    function automatic logic [31:0] imem(input logic [31:0] a);
        case (a)
            32'h20:  return JAL16;
            32'h40:  return BEQ_M8;
            default: return ADDI;
        endcase
    endfunction

    function automatic logic [31:0] exp_target(input logic [31:0] pc, input logic [31:0] ins);
        logic signed [20:0] j;
        logic signed [12:0] b;
        j = {ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
        b = {ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
        if (ins[6:0] == 7'b1101111) return pc + 32'(j);
        return pc + 32'(b);
    endfunction

    // L1I responder: one response per grant after resp_delay idle cycles
    initial begin
        ic_valid   = 1'b0;
        ic_data    = '0;
        resp_addr  = '0;
        resp_stale = 1'b0;
        forever begin
            @(negedge clk);
            if (rst_n && ic_req && ic_gnt) begin
                rs_addr  = ic_addr;
                rs_stale = mispredict;
                n_grant++;
                @(posedge clk);
                for (int d = 0; d < resp_delay; d++) begin
                    @(negedge clk);
                    if (mispredict) rs_stale = 1'b1;
                    @(posedge clk);
                end
                #1;
                resp_addr  = rs_addr;
                resp_stale = rs_stale;
                ic_data    = imem(rs_addr);
                ic_valid   = 1'b1;
                @(posedge clk);
                #1;
                ic_valid = 1'b0;
            end
        end
    end

    // Scoreboard monitor: compare on dequeue, push on accepted response, flush on redirect
    initial begin
        forever begin
            @(negedge clk);
            if (rst_n) begin
                if (f_valid && dec_ready && !mstall) begin
                    total++;
                    if (exp_q.size() == 0) begin
                        bad++;
                        $display("FAIL sb_underflow: dequeued pc=%h but none expected", f_pc);
                    end else begin
                        mon_e = exp_q.pop_front();
                        if (f_instr !== mon_e.instr || f_pc !== mon_e.pc ||
                            f_pc_p4 !== mon_e.pc + 32'd4 || f_pred_taken !== mon_e.pred ||
                            (mon_e.chk_tgt && f_target !== mon_e.target)) begin
                            bad++;
                            $display("FAIL sb_head: got instr=%h pc=%h p4=%h tgt=%h pred=%b want instr=%h pc=%h tgt=%h pred=%b",
                                     f_instr, f_pc, f_pc_p4, f_target, f_pred_taken,
                                     mon_e.instr, mon_e.pc, mon_e.target, mon_e.pred);
                        end
                    end
                end
                if (ic_valid && !resp_stale && !mispredict) begin
                    mon_e.instr   = ic_data;
                    mon_e.pc      = resp_addr;
                    mon_e.target  = exp_target(resp_addr, ic_data);
                    mon_e.chk_tgt = (ic_data[6:0] == 7'b1101111) || (ic_data[6:0] == 7'b1100011);
                    if (ic_data[6:0] == 7'b1101111)      mon_e.pred = 1'b1;
                    else if (ic_data[6:0] == 7'b1100011) mon_e.pred = bht_m[resp_addr[BP_IDX_W+1:2]][1];
                    else                                 mon_e.pred = 1'b0;
                    exp_q.push_back(mon_e);
                    n_enq++;
                end
                if (bp_we) begin
                    if (bp_did_branch && bht_m[bp_w_addr] != 2'b11)       bht_m[bp_w_addr] = bht_m[bp_w_addr] + 2'd1;
                    else if (!bp_did_branch && bht_m[bp_w_addr] != 2'b00) bht_m[bp_w_addr] = bht_m[bp_w_addr] - 2'd1;
                end
                if (mispredict) exp_q.delete();
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic reset_assert();
        gnt_en = 1'b0; dec_ready = 1'b0; mispredict = 1'b0; mstall = 1'b0; bp_we = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        rst_n = 1'b0;
        exp_q.delete();
        for (int i = 0; i < 2**BP_IDX_W; i++) bht_m[i] = 2'b01;
        n_enq = 0; n_grant = 0; resp_delay = 0;
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic reset_release();
        rst_n = 1'b0;
        #1;
        rst_n = 1'b1;
    endtask

    task automatic do_reset();
        reset_assert();
        reset_release();
    endtask

    task automatic wait_grant(output logic [31:0] addr, output bit ok);
        ok = 1'b0;
        addr = 'x;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (ic_req && ic_gnt) begin
                addr = ic_addr;
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic wait_head(output logic [31:0] pc, output bit ok);
        ok = 1'b0;
        pc = 'x;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (f_valid) begin
                pc = f_pc;
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        mispredict = 1'b0; override_addr = '0; mstall = 1'b0;
        bp_we = 1'b0; bp_w_addr = '0; bp_did_branch = 1'b0;
        reset_assert();
        @(negedge clk);
        total++; if (ic_req !== 1'b0)       begin bad++; $display("FAIL rst_ic_req: got %b want 0", ic_req); end
        total++; if (f_valid !== 1'b0)      begin bad++; $display("FAIL rst_f_valid: got %b want 0", f_valid); end
        total++; if (f_pred_taken !== 1'b0) begin bad++; $display("FAIL rst_pred: got %b want 0", f_pred_taken); end
        total++; if (f_instr !== 32'h33)    begin bad++; $display("FAIL rst_f_instr: got %h want 00000033", f_instr); end
        @(posedge clk); #1;
        reset_release();
        @(negedge clk);
        total++; if (ic_req !== 1'b1 || ic_addr !== 32'h0)
            begin bad++; $display("FAIL rst_first_req: got req=%b addr=%h want 1/00000000", ic_req, ic_addr); end
    endtask

    task automatic test_sequential();
        logic [31:0] a;
        bit ok;
        do_reset();
        gnt_en = 1'b1;
        for (int k = 0; k < 3; k++) begin
            wait_grant(a, ok);
            total++;
            if (!ok || a !== 32'(4 * k)) begin bad++; $display("FAIL seq_ic_addr%0d: got %h ok=%0d want %h", k, a, ok, 32'(4 * k)); end
        end
        @(posedge clk); #1;
        dec_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            wait_head(a, ok);
            total++;
            if (!ok || a !== 32'(4 * k)) begin bad++; $display("FAIL seq_f_pc%0d: got %h ok=%0d want %h", k, a, ok, 32'(4 * k)); end
        end
    endtask

    task automatic test_jal();
        logic [31:0] a;
        bit ok;
        bit found;
        do_reset();
        gnt_en = 1'b1; dec_ready = 1'b1;
        found = 1'b0;
        for (int g = 0; g < 20 && !found; g++) begin
            wait_grant(a, ok);
            if (!ok) break;
            if (a == 32'h20) found = 1'b1;
        end
        total++;
        if (!found) begin
            bad++; $display("FAIL jal_reach: fetch never reached 00000020");
        end else begin
            wait_grant(a, ok);
            total++; if (!ok || a !== 32'h30) begin bad++; $display("FAIL jal_next_addr: got %h want 00000030", a); end
            total++; if (f_valid !== 1'b1 || f_pc !== 32'h20 || f_pred_taken !== 1'b1 || f_target !== 32'h30)
                begin bad++; $display("FAIL jal_head: got v=%b pc=%h pred=%b tgt=%h want 1/00000020/1/00000030", f_valid, f_pc, f_pred_taken, f_target); end
        end
    endtask

    task automatic test_branch(input bit trained);
        logic [31:0] a;
        logic [31:0] want_next;
        bit ok;
        bit found;
        do_reset();
        if (trained) begin
            bp_we = 1'b1; bp_w_addr = 8'd16; bp_did_branch = 1'b1;
            repeat (2) @(posedge clk);
            #1;
            bp_we = 1'b0;
        end
        gnt_en = 1'b1; dec_ready = 1'b1;
        want_next = trained ? 32'h38 : 32'h44;
        found = 1'b0;
        for (int g = 0; g < 30 && !found; g++) begin
            wait_grant(a, ok);
            if (!ok) break;
            if (a == 32'h40) found = 1'b1;
        end
        total++;
        if (!found) begin
            bad++; $display("FAIL br_reach: fetch never reached 00000040 trained=%0d", trained);
        end else begin
            wait_grant(a, ok);
            total++; if (!ok || a !== want_next) begin bad++; $display("FAIL br_next_addr: got %h want %h", a, want_next); end
            total++; if (f_valid !== 1'b1 || f_pc !== 32'h40 || f_pred_taken !== trained || f_target !== 32'h38)
                begin bad++; $display("FAIL br_head: got v=%b pc=%h pred=%b tgt=%h want 1/00000040/%b/00000038", f_valid, f_pc, f_pred_taken, f_target, trained); end
        end
    endtask

    task automatic test_full();
        bit ok;
        do_reset();
        gnt_en = 1'b1;
        repeat (20) @(posedge clk);
        @(negedge clk);
        total++; if (n_enq !== FQ_DEPTH)   begin bad++; $display("FAIL full_enq: got %0d want %0d", n_enq, FQ_DEPTH); end
        total++; if (n_grant !== FQ_DEPTH) begin bad++; $display("FAIL full_grant: got %0d want %0d", n_grant, FQ_DEPTH); end
        total++; if (ic_req !== 1'b0 || f_valid !== 1'b1)
            begin bad++; $display("FAIL full_req: got req=%b v=%b want 0/1", ic_req, f_valid); end
        @(posedge clk); #1;
        dec_ready = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < 10 && !ok; i++) begin
            @(negedge clk);
            if (ic_req) ok = 1'b1;
        end
        total++; if (!ok) begin bad++; $display("FAIL full_resume: got req=0 want 1 within 10 cycles"); end
    endtask

    task automatic test_mispredict();
        logic [31:0] a;
        bit ok;
        do_reset();
        gnt_en = 1'b1; resp_delay = 2;
        for (int k = 0; k < 3; k++) wait_grant(a, ok);
        @(posedge clk); #1;
        mispredict = 1'b1; override_addr = 32'h100;
        @(negedge clk);
        total++; if (f_valid !== 1'b1) begin bad++; $display("FAIL mp_pre_valid: got %b want 1", f_valid); end
        @(posedge clk); #1;
        mispredict = 1'b0;
        @(negedge clk);
        total++; if (f_valid !== 1'b0 || ic_req !== 1'b0)
            begin bad++; $display("FAIL mp_flush: got v=%b req=%b want 0/0", f_valid, ic_req); end
        ok = 1'b0;
        for (int i = 0; i < 10 && !ok; i++) begin
            if (ic_valid) ok = 1'b1;
            else @(negedge clk);
        end
        total++; if (!ok) begin bad++; $display("FAIL mp_late_resp: got no ic_valid want one"); end
        @(negedge clk);
        total++; if (f_valid !== 1'b0) begin bad++; $display("FAIL mp_dropped: got v=%b want 0", f_valid); end
        total++; if (ic_req !== 1'b1 || ic_addr !== 32'h100)
            begin bad++; $display("FAIL mp_redirect: got req=%b addr=%h want 1/00000100", ic_req, ic_addr); end
        @(posedge clk); #1;
        resp_delay = 0; dec_ready = 1'b1;
        wait_head(a, ok);
        total++; if (!ok || a !== 32'h100) begin bad++; $display("FAIL mp_head: got %h want 00000100", a); end
    endtask

    task automatic test_mstall();
        bit ok;
        do_reset();
        gnt_en = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < 40 && !ok; i++) begin
            @(negedge clk);
            if (n_enq == FQ_DEPTH) ok = 1'b1;
        end
        total++; if (!ok) begin bad++; $display("FAIL stall_fill: got %0d entries want %0d", n_enq, FQ_DEPTH); end
        @(posedge clk); #1;
        mstall = 1'b1; dec_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            total++; if (f_valid !== 1'b1 || f_pc !== 32'h0)
                begin bad++; $display("FAIL stall_hold%0d: got v=%b pc=%h want 1/00000000", i, f_valid, f_pc); end
        end
        @(posedge clk); #1;
        mstall = 1'b0;
        @(negedge clk);
        @(negedge clk);
        total++; if (f_valid !== 1'b1 || f_pc !== 32'h4)
            begin bad++; $display("FAIL stall_release: got v=%b pc=%h want 1/00000004", f_valid, f_pc); end
    endtask

    task automatic test_back_to_back();
        do_reset();
        gnt_en = 1'b1;
        for (int c = 0; c < 400; c++) begin
            @(posedge clk); #1;
            dec_ready     = ($urandom_range(0, 3) != 0);
            mstall        = ($urandom_range(0, 7) == 0);
            gnt_en        = ($urandom_range(0, 3) != 0);
            resp_delay    = $urandom_range(0, 2);
            mispredict    = ($urandom_range(0, 15) == 0);
            override_addr = 32'($urandom_range(0, 31)) << 2;
            bp_we         = ($urandom_range(0, 3) == 0);
            bp_w_addr     = BP_IDX_W'($urandom_range(0, 31));
            bp_did_branch = $urandom_range(0, 1) != 0;
        end
        @(posedge clk); #1;
        mispredict = 1'b0; mstall = 1'b0; bp_we = 1'b0; gnt_en = 1'b0; dec_ready = 1'b1;
        repeat (12) @(posedge clk);
        @(negedge clk);
        total++; if (exp_q.size() != 0 || f_valid !== 1'b0)
            begin bad++; $display("FAIL b2b_drain: got %0d pending, v=%b want 0/0", exp_q.size(), f_valid); end
    endtask

    initial begin
        test_reset();
        test_sequential();
        test_jal();
        test_branch(1'b1);
        test_branch(1'b0);
        test_full();
        test_mispredict();
        test_mstall();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
